// File: rtl/rr_priority_encoder.sv
// N-to-log2(N) priority encoder with fixed or round-robin priority and a single
// registered valid/ready output stage (no skid buffer).
module rr_priority_encoder #(
    parameter  int N    = 8,
    parameter  int MODE = 1,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_none,
    output logic         out_multi
);

    localparam logic [W:0]   N_EXT  = (W+1)'(N);
    localparam logic [W-1:0] LAST   = W'(N - 1);
    localparam logic [W-1:0] ONE_W  = W'(1);
    localparam logic [N-1:0] ONE_N  = N'(1);

    // Rotate so that bit 0 of the result is request bit 'sh'.
    function automatic logic [N-1:0] rotate_right(input logic [N-1:0] req,
                                                  input logic [W-1:0] sh);
        logic [2*N-1:0] dbl;
        dbl = {req, req} >> sh;
        return dbl[N-1:0];
    endfunction

    function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    // Modulo-N add; N need not be a power of two.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_EXT) s = s - N_EXT;
        return s[W-1:0];
    endfunction

    logic         r_valid;
    logic [W-1:0] r_idx;
    logic         r_none;
    logic         r_multi;
    logic [W-1:0] r_ptr;

    logic         w_accept;
    logic [N-1:0] w_rot;
    logic [W-1:0] w_off;
    logic [W-1:0] w_win;
    logic         w_none;
    logic         w_multi;
    logic [W-1:0] w_ptr_nxt;

    assign in_ready  = !rst && (!r_valid || out_ready);
    assign w_accept  = in_valid && in_ready;

    assign w_rot     = rotate_right(in_req, r_ptr);
    assign w_off     = lowest_set(w_rot);
    assign w_win     = wrap_add(r_ptr, w_off);
    assign w_none    = (in_req == '0);
    assign w_multi   = ((in_req & (in_req - ONE_N)) != '0);
    assign w_ptr_nxt = (w_win == LAST) ? '0 : (w_win + ONE_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_none  <= 1'b0;
            r_multi <= 1'b0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_idx   <= w_none ? '0 : w_win;
            r_none  <= w_none;
            r_multi <= w_multi;
            // Fixed-priority mode keeps the pointer parked at 0.
            if (MODE != 0 && !w_none) r_ptr <= w_ptr_nxt;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign out_none  = r_none;
    assign out_multi = r_multi;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench: a 4-wide fixed-priority instance and an 8-wide round-robin
// instance share clock and reset; expected results are queued on accept.
module tb_rr_priority_encoder;

    typedef struct {
        int idx;
        bit none;
        bit multi;
        int acc;
        bit lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, out_none4, out_multi4;
    logic [3:0] in_req4;
    logic [1:0] out_idx4;
    logic       in_valid8, in_ready8, out_valid8, out_ready8, out_none8, out_multi8;
    logic [7:0] in_req8;
    logic [2:0] out_idx8;

    exp_t q4[$];
    exp_t q8[$];
    int   ptr8 = 0;

    rr_priority_encoder #(.N(4), .MODE(0)) u_fix4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_req(in_req4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_idx(out_idx4), .out_none(out_none4), .out_multi(out_multi4)
    );

    rr_priority_encoder #(.N(8), .MODE(1)) u_rr8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_req(in_req8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_idx(out_idx8), .out_none(out_none8), .out_multi(out_multi8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference search: first set bit at or above ptr, wrapping modulo n.
    function automatic int model_idx(input logic [7:0] req, input int ptr, input int n);
        for (int i = 0; i < n; i++) begin
            if (req[(ptr + i) % n]) return (ptr + i) % n;
        end
        return 0;
    endfunction

    function automatic exp_t make_exp(input logic [7:0] req, input int ptr,
                                      input int n, input bit lat);
        exp_t e;
        e.idx   = model_idx(req, ptr, n);
        e.none  = (req == 8'h00);
        e.multi = ($countones(req) >= 2);
        e.acc   = cyc;
        e.lat   = lat;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send8(input logic [7:0] req, input bit lat);
        int   n;
        bit   ok;
        exp_t e;
        n  = 0;
        ok = 1'b0;
        in_valid8 = 1'b1;
        in_req8   = req;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (in_ready8) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            chk("u8_accept_timeout", 0, 1);
        end else begin
            e = make_exp(req, ptr8, 8, lat);
            q8.push_back(e);
            if (req != 8'h00) ptr8 = (e.idx + 1) % 8;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [3:0] req);
        int   n;
        bit   ok;
        n  = 0;
        ok = 1'b0;
        in_valid4 = 1'b1;
        in_req4   = req;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (in_ready4) ok = 1'b1;
            else n++;
        end
        if (!ok) chk("u4_accept_timeout", 0, 1);
        else q4.push_back(make_exp({4'b0, req}, 0, 4, 1'b1));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                chk("u8_unexpected_output", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("u8_idx", int'(out_idx8), e.idx);
                chk("u8_none", int'(out_none8), int'(e.none));
                chk("u8_multi", int'(out_multi8), int'(e.multi));
                if (e.lat) chk("u8_latency", cyc, e.acc + 1);
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                chk("u4_unexpected_output", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("u4_idx", int'(out_idx4), e.idx);
                chk("u4_none", int'(out_none4), int'(e.none));
                chk("u4_multi", int'(out_multi4), int'(e.multi));
                if (e.lat) chk("u4_latency", cyc, e.acc + 1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid4  = 1'b0;
        in_req4    = '0;
        out_ready4 = 1'b1;
        in_valid8  = 1'b1;
        in_req8    = 8'hFF;
        out_ready8 = 1'b1;

        // Reset held two cycles with a request offered.
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", int'(in_ready8), 0);
            chk("rst_out_valid", int'(out_valid8), 0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid8 = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready8), 1);
        chk("post_rst_out_valid", int'(out_valid8), 0);
        @(negedge clk);
        chk("post_rst_no_xfer", int'(out_valid8), 0);
        @(posedge clk);
        #1;
        send8(8'hFF, 1'b1);
        in_valid8 = 1'b0;

        // Fixed priority: one-hot sweep back-to-back, then flags.
        send4(4'b0001);
        send4(4'b0010);
        send4(4'b0100);
        send4(4'b1000);
        send4(4'b0000);
        send4(4'b1010);
        send4(4'b1000);
        in_valid4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("u4_valid_cleared", int'(out_valid4), 0);
        @(posedge clk);
        #1;

        // Fresh pointer for the round-robin sequence.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        ptr8 = 0;
        send8(8'hFF, 1'b1);
        send8(8'hFF, 1'b1);
        send8(8'hFF, 1'b1);
        send8(8'hFF, 1'b1);
        send8(8'h81, 1'b1);
        send8(8'h81, 1'b1);
        send8(8'h00, 1'b1);
        send8(8'h81, 1'b1);
        in_valid8 = 1'b0;
        @(posedge clk);
        #1;

        // Backpressure: result held, second vector stalled until out_ready.
        send8(8'h0C, 1'b0);
        out_ready8 = 1'b0;
        in_valid8  = 1'b1;
        in_req8    = 8'h0C;
        repeat (3) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid8), 1);
            chk("bp_out_idx", int'(out_idx8), 2);
            chk("bp_in_ready", int'(in_ready8), 0);
        end
        @(posedge clk);
        #1;
        out_ready8 = 1'b1;
        send8(8'h0C, 1'b1);
        in_valid8 = 1'b0;
        @(posedge clk);
        #1;

        // Reset while a result is pending and stalled.
        send8(8'hFF, 1'b0);
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        chk("midrst_pending", int'(out_valid8), 1);
        chk("midrst_in_ready", int'(in_ready8), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q8.delete();
        ptr8 = 0;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid8), 0);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        send8(8'hFF, 1'b1);
        in_valid8 = 1'b0;

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rr_priority_encoder.md
# rr_priority_encoder

Parametrised N-to-log2(N) priority encoder with a registered valid/ready output stage and a selectable fixed or round-robin priority scheme. It generalises the team's 4:2 one-hot encoder to arbitrary width. It adds zero-input and multi-hot detection flags, and it holds state between transactions through a rotating priority pointer. It sits between request sources (interrupt lines, channel requests) and a downstream consumer that needs one index per accepted request vector.

## Interface
- N, default 8: request vector width; legal range 2..64, not required to be a power of two.
- MODE, default 1: 0 = fixed priority, lowest index wins; 1 = round-robin from a rotating pointer.
- W (localparam, not overridable): $clog2(N), width of the output index.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a request vector is offered.
- in_ready  output  1  the block accepts in_req this cycle.
- in_req  input  N  request vector; bit i set means source i is requesting.
- out_valid  output  1  the result register holds a valid result.
- out_ready  input  1  the consumer takes the result this cycle.
- out_idx  output  W  encoded index of the winning request bit.
- out_none  output  1  the accepted vector was all zeros.
- out_multi  output  1  the accepted vector had two or more bits set.

## Operation
- Accept: a request is accepted when in_valid && in_ready.
- in_ready = !rst && (!out_valid || out_ready). This is combinational and gives single-stage pass-through with no skid buffer.
- On accept, the block computes the winner from in_req and the pointer ptr (W bits), then registers out_idx, out_none and out_multi, and sets out_valid.
- MODE 0: ptr is held at 0. The winner is the lowest set bit index.
- MODE 1: the search starts at ptr and moves upward, wrapping from N-1 to 0. The winner is the first set bit found.
- Pointer update (MODE 1 only): on an accept with a nonzero vector, ptr <= winner+1, or 0 when winner = N-1. The pointer never takes a value of N or above.
- Zero vector: out_none=1, out_idx=0, out_multi=0, and ptr is unchanged. This is still a valid transfer.
- out_multi is set when the popcount of in_req is 2 or more. It is independent of MODE.
- Hold: while out_valid && !out_ready, all output registers and ptr stay stable.
- Completion: out_ready with out_valid and no new accept clears out_valid next cycle. out_idx, out_none and out_multi then keep their last values and are don't-care.
- Simultaneous events: output taken and new input accepted in the same cycle gives back-to-back results with out_valid staying 1.
- Reset: rst=1 at a clock edge forces out_valid=0, out_idx=0, out_none=0, out_multi=0 and ptr=0.
  - in_ready is 0 while rst is high.
  - Any pending result is discarded, and a request offered during reset is not accepted.

## Timing
- Latency: 1 cycle. A vector accepted at edge k appears on the outputs after edge k, with out_valid=1 in cycle k+1.
- Throughput: 1 result per cycle while out_ready is held high.
- Pointer timing: ptr updates at the accept edge, so a request accepted in the next cycle already uses the new pointer.
- First cycle after rst deasserts: in_ready=1 and out_valid=0.
- Outputs come directly from registers. The only combinational output is in_ready, through out_ready.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 and in_req=8'hFF.
  - Required: in_ready=0 and out_valid=0 throughout, and no transfer afterward.
  - After release: in_ready=1, and the first accepted 8'hFF gives out_idx=0.
- One-hot sweep (N=4, MODE 0): feed 0001, 0010, 0100, 1000 back-to-back with out_ready=1.
  - Required: out_idx=0,1,2,3 on consecutive cycles starting 1 cycle after the first accept.
  - out_none=0 and out_multi=0 for all four.
- Flags (N=4, MODE 0): 0000 -> out_none=1, out_idx=0. 1010 -> out_idx=1, out_multi=1. 1000 -> out_idx=3, out_multi=0.
- Round-robin (N=8, MODE 1): 8'hFF four times -> out_idx=0,1,2,3.
  - Then 8'h81 -> 7, then 8'h81 -> 0 (wrap), then 8'h00 -> out_none=1, then 8'h81 -> 7 (pointer unchanged by the zero vector).
- Backpressure (N=8, MODE 1): accept 8'h0C, then hold out_ready=0 for 3 cycles with in_valid=1 and in_req=8'h0C.
  - Required: out_idx=2 held stable, in_ready=0, no second accept.
  - On out_ready=1: the second vector is accepted that cycle and gives out_idx=3 next cycle.
- Reset mid-operation: with out_valid=1 and out_ready=0, pulse rst for 1 cycle.
  - Required: out_valid=0 and ptr=0. The next accepted 8'hFF gives out_idx=0.
